sram_resp_mem: RTL and testbench

- Responder end of the core's SRAM-like instruction and data interfaces.
- Provides a dual-port word memory with one-cycle read latency and byte-write enables, plus a small memory-mapped register window (free-running timer, LED, numeric display).
- Instantiated beside the CPU core in the SoC top. Its inst port faces the IF/ID fetch path; its data port faces EX/MEM load/store.

---
 rtl/sram_resp_mem_if.sv | 25 ++
 rtl/sram_resp_mem.sv | 123 ++++++++++++
 tb/tb_sram_resp_mem.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_resp_mem_if.sv
// SRAM-like instruction/data bus between the CPU core (master) and its memory responder (slave).
interface sram_resp_mem_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_resp_mem.sv
// Responder for the core's inst/data SRAM ports: dual-port word memory with
// one-cycle read-first access plus a timer/LED/NUM register window.
module sram_resp_mem #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] CONF_BASE  = 32'h1faf_0000
) (
    input  logic             clk,
    input  logic             rst,
    sram_resp_mem_if.slave   bus,
    output logic [15:0]      led,
    output logic [31:0]      num,
    output logic             addr_err
);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [15:0] OFF_TIMER = 16'h8000;
    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_NUM   = 16'hf020;

    logic [31:0] mem [DEPTH];
    logic [31:0] timer;

    logic [31:0]           inst_phys, data_phys;
    logic [ADDR_WIDTH-1:0] inst_idx, data_idx;
    logic                  inst_mem_hit, inst_conf_hit, data_mem_hit, data_conf_hit;
    logic [31:0]           inst_conf_rd, data_conf_rd;
    logic                  data_wr, wr_mem, wr_timer, wr_led, wr_num;
    logic [31:0]           timer_merged, led_merged, num_merged;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity-mapped
    function automatic logic [31:0] to_phys(input logic [31:0] a);
        return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] wen);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] conf_rd(input logic [13:0] off, input logic [31:0] t,
                                            input logic [15:0] l, input logic [31:0] n);
        case (off)
            OFF_TIMER[15:2]: return t;
            OFF_LED[15:2]:   return {16'h0, l};
            OFF_NUM[15:2]:   return n;
            default:         return 32'h0;
        endcase
    endfunction

    always_comb begin
        inst_phys     = to_phys(bus.inst_sram_addr);
        data_phys     = to_phys(bus.data_sram_addr);
        inst_idx      = inst_phys[ADDR_WIDTH+1:2];
        data_idx      = data_phys[ADDR_WIDTH+1:2];
        inst_mem_hit  = (inst_phys[31:ADDR_WIDTH+2] == '0);
        data_mem_hit  = (data_phys[31:ADDR_WIDTH+2] == '0);
        inst_conf_hit = (inst_phys[31:16] == CONF_BASE[31:16]);
        data_conf_hit = (data_phys[31:16] == CONF_BASE[31:16]);
        inst_conf_rd  = conf_rd(inst_phys[15:2], timer, led, num);
        data_conf_rd  = conf_rd(data_phys[15:2], timer, led, num);

        data_wr  = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
        wr_mem   = data_wr && data_mem_hit;
        wr_timer = data_wr && data_conf_hit && (data_phys[15:2] == OFF_TIMER[15:2]);
        wr_led   = data_wr && data_conf_hit && (data_phys[15:2] == OFF_LED[15:2]);
        wr_num   = data_wr && data_conf_hit && (data_phys[15:2] == OFF_NUM[15:2]);

        timer_merged = merge(timer, bus.data_sram_wdata, bus.data_sram_wen);
        led_merged   = merge({16'h0, led}, bus.data_sram_wdata, bus.data_sram_wen);
        num_merged   = merge(num, bus.data_sram_wdata, bus.data_sram_wen);
    end

    // Array has no reset; a request presented during reset never writes
    always_ff @(posedge clk) begin
        if (!rst && wr_mem) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) mem[data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Read ports sample the pre-edge array and registers (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.inst_sram_rdata <= 32'h0;
            bus.data_sram_rdata <= 32'h0;
        end else begin
            if (bus.inst_sram_en) begin
                if (inst_mem_hit)       bus.inst_sram_rdata <= mem[inst_idx];
                else if (inst_conf_hit) bus.inst_sram_rdata <= inst_conf_rd;
                else                    bus.inst_sram_rdata <= 32'h0;
            end
            if (bus.data_sram_en) begin
                if (data_mem_hit)       bus.data_sram_rdata <= mem[data_idx];
                else if (data_conf_hit) bus.data_sram_rdata <= data_conf_rd;
                else                    bus.data_sram_rdata <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= 32'h0;
            led      <= 16'h0;
            num      <= 32'h0;
            addr_err <= 1'b0;
        end else begin
            timer <= wr_timer ? timer_merged : timer + 32'd1;
            if (wr_led) led <= led_merged[15:0];
            if (wr_num) num <= num_merged;
            addr_err <= (bus.inst_sram_en && !inst_mem_hit && !inst_conf_hit) ||
                        (bus.data_sram_en && !data_mem_hit && !data_conf_hit);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, inst_phys[1:0],
                           data_phys[1:0], led_merged[31:16]};
endmodule

// File: tb/tb_sram_resp_mem.sv
// Scoreboard bench for sram_resp_mem: a behavioural model predicts every output per cycle.
module tb_sram_resp_mem;
    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic [31:0] num;
    logic        addr_err;

    sram_resp_mem_if bus ();

    sram_resp_mem dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .led      (led),
        .num      (num),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [31:0] d;
        logic        e;
        logic [15:0] led;
        logic [31:0] num;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] m_timer, m_num, m_i, m_d;
    logic [15:0] m_led;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] phys(input logic [31:0] a);
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return a & 32'h1fff_ffff;
        return a;
    endfunction

    // 0 = memory, 1 = register window, 2 = unmapped
    function automatic int region(input logic [31:0] a);
        logic [31:0] p;
        p = phys(a);
        if (p < 32'h0000_4000) return 0;
        if (p[31:16] == 16'h1faf) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] w);
        logic [31:0] m;
        m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] p;
        p = phys(a);
        case (region(a))
            0: return mem_m.exists(int'(p[13:2])) ? mem_m[int'(p[13:2])] : 32'hxxxx_xxxx;
            1: begin
                case ({p[15:2], 2'b00})
                    16'h8000: return m_timer;
                    16'hf000: return {16'h0, m_led};
                    16'hf020: return m_num;
                    default:  return 32'h0;
                endcase
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic r, input logic ie, input logic [31:0] ia,
                        input logic de, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd);
        exp_t        e;
        logic [31:0] p, tmp;
        logic        tw;
        rst                 = r;
        bus.inst_sram_en    = ie;
        bus.inst_sram_addr  = ia;
        bus.inst_sram_wen   = 4'($urandom);
        bus.inst_sram_wdata = $urandom;
        bus.data_sram_en    = de;
        bus.data_sram_wen   = dw;
        bus.data_sram_addr  = da;
        bus.data_sram_wdata = dd;
        if (r) begin
            e = '{i: 32'h0, d: 32'h0, e: 1'b0, led: 16'h0, num: 32'h0};
            m_timer = 32'h0;
            m_led   = 16'h0;
            m_num   = 32'h0;
        end else begin
            e.i = ie ? m_read(ia) : m_i;
            e.d = de ? m_read(da) : m_d;
            e.e = (ie && region(ia) == 2) || (de && region(da) == 2);
            tw  = 1'b0;
            p   = phys(da);
            if (de && dw != 4'b0000) begin
                if (region(da) == 0) begin
                    mem_m[int'(p[13:2])] = merge(m_read(da), dd, dw);
                end else if (region(da) == 1) begin
                    case ({p[15:2], 2'b00})
                        16'h8000: begin m_timer = merge(m_timer, dd, dw); tw = 1'b1; end
                        16'hf000: begin tmp = merge({16'h0, m_led}, dd, dw); m_led = tmp[15:0]; end
                        16'hf020: m_num = merge(m_num, dd, dw);
                        default: ;
                    endcase
                end
            end
            if (!tw) m_timer = m_timer + 32'd1;
            e.led = m_led;
            e.num = m_num;
        end
        m_i = e.i;
        m_d = e.d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("inst_rdata", bus.inst_sram_rdata, e.i);
        chk("data_rdata", bus.data_sram_rdata, e.d);
        chk("addr_err", 32'(addr_err), 32'(e.e));
        chk("led", 32'(led), 32'(e.led));
        chk("num", num, e.num);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int          k;
        logic [31:0] seg;
        k = $urandom_range(0, 21);
        case ($urandom_range(0, 2))
            0:       seg = 32'h0000_0000;
            1:       seg = 32'h8000_0000;
            default: seg = 32'hA000_0000;
        endcase
        if (k < 16) return seg | 32'(k * 4) | 32'($urandom_range(0, 3));
        case (k)
            16: return 32'hBFAF_8000;
            17: return 32'hBFAF_F000;
            18: return 32'hBFAF_F020;
            19: return 32'hBFAF_0004;
            20: return 32'h1000_0000;
            default: return 32'h0001_0000;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'(i * 4), (i == 8) ? 32'h0 : $urandom);

        // Write through kseg0, read back through kseg1 alias
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'h8000_0010, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hA000_0010, 32'h0);
        chk("wr_rd_alias", bus.data_sram_rdata, 32'hDEADBEEF);

        step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'h0000_0010, 32'h11223344);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0101, 32'h0000_0010, 32'hAABBCCDD);
        chk("read_first", bus.data_sram_rdata, 32'h11223344);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        chk("byte_lanes", bus.data_sram_rdata, 32'h11BB33DD);

        step(1'b0, 1'b1, 32'h0000_0020, 1'b1, 4'hf, 32'h0000_0020, 32'hCAFEF00D);
        chk("collide_old", bus.inst_sram_rdata, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0020, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("collide_new", bus.inst_sram_rdata, 32'hCAFEF00D);

        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (10) idle();
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_8000, 32'h0);
        chk("timer_10", bus.data_sram_rdata, 32'h0000_000A);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'hBFAF_8000, 32'hFFFF_FFFF);
        idle();
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_8000, 32'h0);
        chk("timer_wrap", bus.data_sram_rdata, 32'h0);

        step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'hBFAF_F000, 32'h1234_5678);
        chk("led_write", 32'(led), 32'h0000_5678);
        step(1'b0, 1'b1, 32'hBFAF_F000, 1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        chk("led_read", bus.data_sram_rdata, 32'h0000_5678);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'b1000, 32'hBFAF_F020, 32'hAB00_0000);
        chk("num_write", num, 32'hAB00_0000);

        step(1'b0, 1'b0, 32'h0, 1'b1, 4'hf, 32'h1000_0000, 32'h5555_5555);
        chk("unmapped_err", 32'(addr_err), 32'h1);
        idle();
        chk("unmapped_clr", 32'(addr_err), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);

        // Request under reset: inst read of unmapped address, data write to word 5
        step(1'b1, 1'b1, 32'h1000_0000, 1'b1, 4'hf, 32'h8000_0014, 32'h9999_9999);
        chk("rst_inst", bus.inst_sram_rdata, 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        step(1'b0, 1'b1, 32'h8000_0014, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        chk("mem_kept", bus.data_sram_rdata, 32'h11BB33DD);

        for (int n = 0; n < 400; n++) begin
            logic        rr, ie, de;
            logic [3:0]  w;
            rr = ($urandom_range(0, 99) == 0);
            ie = 1'($urandom);
            de = 1'($urandom);
            w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(rr, ie, rand_addr(), de, w, rand_addr(), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
